// File: rtl/branch_update_unit.sv
// Resolved-branch update FIFO feeding a table of 2-bit saturating counters, with registered lookup.
// Optional mispredict statistics counter enabled by defining BRANCH_UPDATE_STATS_EN.
module branch_update_unit #(
    parameter int LOWER      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [LOWER-1:0] upd_addr,
    input  logic             upd_taken,
    input  logic             upd_jumped,
    input  logic             upd_pred,
    input  logic [LOWER-1:0] rd_addr,
    output logic             prediction,
    output logic             mispredict,
    output logic [15:0]      mispredict_cnt
);
    localparam int ROW_W = LOWER - 2;
    localparam int ROWS  = 1 << ROW_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic             outcome;
        logic             pred;
    } entry_t;

    entry_t           fifo_q [FIFO_DEPTH];
    logic [1:0]       ctr_q  [ROWS];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             prediction_q, prediction_d;
    logic             mispredict_q, mispredict_d;
    logic             push, pop, full, empty;
    entry_t           head, new_entry;
    logic [1:0]       head_ctr, head_ctr_d;

    // PC bits [1:0] never select a row.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{upd_addr[1:0], rd_addr[1:0]};

    assign full      = (occ_q == OCC_W'(FIFO_DEPTH));
    assign empty     = (occ_q == '0);
    assign upd_ready = ~full;
    assign push      = upd_valid & ~full;
    assign pop       = en & ~empty;
    assign head      = fifo_q[rd_ptr_q];
    assign head_ctr  = ctr_q[head.row];
    assign new_entry = '{row: upd_addr[LOWER-1:2], outcome: upd_taken | upd_jumped, pred: upd_pred};

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        head_ctr_d   = head_ctr;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;
        prediction_d = prediction_q;
        mispredict_d = 1'b0;

        if (head.outcome && head_ctr != 2'b11) begin
            head_ctr_d = head_ctr + 2'd1;
        end else if (!head.outcome && head_ctr != 2'b00) begin
            head_ctr_d = head_ctr - 2'd1;
        end

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        // The table is read before this edge's write lands, so a colliding row shows its old value.
        if (en) prediction_d = ctr_q[rd_addr[LOWER-1:2]][1];
        mispredict_d = pop & (head.pred != head.outcome);
    end

    // NOTE: FIFO storage has no reset; occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= new_entry;
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            for (int r = 0; r < ROWS; r++) begin
                ctr_q[r[ROW_W-1:0]] <= (r == 4) ? 2'b01 : 2'b00;
            end
        end else if (pop) begin
            ctr_q[head.row] <= head_ctr_d;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            prediction_q <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            prediction_q <= prediction_d;
            mispredict_q <= mispredict_d;
        end
    end

    assign prediction = prediction_q;
    assign mispredict = mispredict_q;

`ifdef BRANCH_UPDATE_STATS_EN
    logic [15:0] mispredict_cnt_q;

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            mispredict_cnt_q <= '0;
        end else if (mispredict_d && mispredict_cnt_q != 16'hFFFF) begin
            mispredict_cnt_q <= mispredict_cnt_q + 16'd1;
        end
    end

    assign mispredict_cnt = mispredict_cnt_q;
`else
    assign mispredict_cnt = '0;
`endif

endmodule

// File: doc/branch_update_unit.md
BRANCH_UPDATE_UNIT -- requirements
Module: branch_update_unit

Interface
REQ-001 SHALL have parameter LOWER, default 5, giving the number of low PC bits used for the table index.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, giving the number of buffered resolved-branch updates (power of 2, at least 2).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port arst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port en, input, 1 bit: global stall; when 0, no FIFO pop, no counter write and no prediction register update.
REQ-006 SHALL have port upd_valid, input, 1 bit: a resolved-branch update is offered.
REQ-007 SHALL have port upd_ready, output, 1 bit: the FIFO can accept an update.
REQ-008 SHALL have port upd_addr, input, LOWER bits: the PC low bits of the resolved branch.
REQ-009 SHALL have port upd_taken, input, 1 bit: the conditional branch was taken.
REQ-010 SHALL have port upd_jumped, input, 1 bit: an unconditional jump was taken.
REQ-011 SHALL have port upd_pred, input, 1 bit: the prediction issued for this branch.
REQ-012 SHALL have port rd_addr, input, LOWER bits: the fetch-side lookup index.
REQ-013 SHALL have port prediction, output, 1 bit: registered MSB of the addressed counter.
REQ-014 SHALL have port mispredict, output, 1 bit: one-cycle pulse on a misprediction.
REQ-015 SHALL have port mispredict_cnt, output, 16 bits: the statistics counter (see Configuration).

Function
REQ-016 SHALL hold 2^(LOWER-2) two-bit saturating counters, with row index = addr[LOWER-1:2] (8 rows at the default LOWER).
REQ-017 SHALL accept an update when upd_valid=1 and upd_ready=1 at a clock edge; upd_ready SHALL equal NOT full.
REQ-018 SHALL, when en=1 and the FIFO is non-empty, pop one entry per cycle and write that entry's counter at the same edge.
REQ-019 SHALL treat the outcome as O = upd_taken OR upd_jumped; O=1 increments the counter, saturating at 2'b11; O=0 decrements it, saturating at 2'b00.
REQ-020 SHALL, on each pop where the entry's upd_pred differs from O, set mispredict=1 for exactly the cycle after that edge; otherwise mispredict=0.
REQ-021 SHALL, when en=1, register prediction from counter[rd_addr row][1] using the pre-write value when that row is written at the same edge; one-cycle latency.
REQ-022 SHALL, when the FIFO is full, keep upd_ready=0 even if a pop occurs at the same edge; the push is refused and the upstream retries.
REQ-023 SHALL, when the FIFO is empty and a push occurs at the same edge, not apply the pushed entry until the following cycle (no bypass).
REQ-024 SHALL, when push and pop occur together on a non-full, non-empty FIFO, keep the occupancy unchanged.
REQ-025 SHALL, when en=0, still accept pushes while not full, and SHALL hold prediction and the counters.
REQ-026 SHALL implement pointer wrap-around modulo FIFO_DEPTH, with a separate occupancy count of width log2(FIFO_DEPTH)+1.

Reset
REQ-027 SHALL, while arst_n=0 at a clock edge, reset all counters to 2'b00 except row 4, which resets to 2'b01.
REQ-028 SHALL, on reset, empty the FIFO, giving upd_ready=1, and set prediction=0, mispredict=0 and mispredict_cnt=0.
REQ-029 SHALL, on reset asserted mid-operation, discard queued updates without applying them.

Configuration
REQ-030 SHALL, with macro BRANCH_UPDATE_STATS_EN defined, increment mispredict_cnt by 1 on each mispredict event, saturating at 16'hFFFF.
REQ-031 SHALL, with BRANCH_UPDATE_STATS_EN undefined, tie mispredict_cnt to 0 and include no counter logic.

Verification
REQ-032 SHALL verify: after reset, rd_addr=5'd16 -> prediction=0 (row4 counter=01); push two updates with addr=16 and taken=1 -> after the drain, prediction=1 (counter=11).
REQ-033 SHALL verify: four updates with addr=0 and taken=0 on a reset counter -> counter stays at 00, prediction=0 and mispredict=0 when upd_pred=0.
REQ-034 SHALL verify: en=0 with 4 pushes -> upd_ready=0 after the 4th; a 5th upd_valid is held off; en=1 -> 4 pops on consecutive cycles and upd_ready=1 the cycle after the first pop.
REQ-035 SHALL verify: an update with upd_pred=0, jumped=1 -> mispredict pulses high for exactly 1 cycle, and mispredict_cnt=1 with BRANCH_UPDATE_STATS_EN defined, 0 without.
REQ-036 SHALL verify: a same-cycle write and read of row 2 (counter 01 -> 10) -> prediction shows 0 that cycle and 1 on the next read.
REQ-037 SHALL verify: reset asserted with 3 entries queued -> no counter changes, upd_ready=1 and mispredict=0 after reset.
